// File: rtl/forward_sb.sv
// Operand bypass select plus per-register countdown scoreboard for the N-wide issue bundle.
// Define FWD_STATS_EN to build the stall-cycle and forwarded-operand counters.
module forward_sb #(
    parameter int LANES  = 2,
    parameter int SRCS   = 3,
    parameter int STAGES = 2,
    parameter int LATW   = 3
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         flush,
    input  logic [LANES-1:0]             iss_valid,
    input  logic [LANES-1:0]             iss_we,
    input  logic [LANES*5-1:0]           iss_rd,
    input  logic [LANES*LATW-1:0]        iss_lat,
    input  logic [LANES*SRCS*5-1:0]      src_reg,
    input  logic [LANES*SRCS*32-1:0]     src_rf,
    input  logic [STAGES*LANES-1:0]      byp_we,
    input  logic [STAGES*LANES*5-1:0]    byp_rd,
    input  logic [STAGES*LANES*32-1:0]   byp_data,
    output logic [LANES*SRCS*32-1:0]     src_val,
    output logic                         stall,
    output logic [31:0]                  stat_stall,
    output logic [31:0]                  stat_fwd
);

    localparam int NOPS = LANES * SRCS;

    logic [NOPS-1:0]  fwd_hit;
    logic [LANES-1:0] acc;
    logic [LATW-1:0]  cnt_q [32];
    logic [LATW-1:0]  cnt_d [32];

    // Youngest stage first, and within a stage the highest lane is the youngest.
    always_comb begin : operand_sel
        src_val = src_rf;
        fwd_hit = '0;
        for (int o = 0; o < NOPS; o++) begin
            if (src_reg[o*5 +: 5] != 5'd0) begin
                for (int st = 0; st < STAGES; st++) begin
                    for (int ln = LANES - 1; ln >= 0; ln--) begin
                        if (!fwd_hit[o] && byp_we[st*LANES+ln] &&
                            (byp_rd[(st*LANES+ln)*5 +: 5] == src_reg[o*5 +: 5])) begin
                            src_val[o*32 +: 32] = byp_data[(st*LANES+ln)*32 +: 32];
                            fwd_hit[o]          = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin : stall_calc
        stall = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            for (int s = 0; s < SRCS; s++) begin
                if (iss_valid[l] && (src_reg[(l*SRCS+s)*5 +: 5] != 5'd0) &&
                    (cnt_q[src_reg[(l*SRCS+s)*5 +: 5]] != '0)) begin
                    stall = 1'b1;
                end
            end
        end
    end

    always_comb begin : accept_calc
        for (int l = 0; l < LANES; l++) begin
            acc[l] = iss_valid[l] & iss_we[l] & ~stall & ~flush &
                     (iss_rd[l*5 +: 5] != 5'd0) & (iss_lat[l*LATW +: LATW] != '0);
        end
    end

    // Reloading never shortens a pending countdown, so a WAW consumer waits for the later producer.
    always_comb begin : sb_next
        logic [LATW-1:0] dec;
        logic [LATW-1:0] lat_sel;
        logic            load;
        for (int r = 0; r < 32; r++) begin
            dec     = (cnt_q[r] != '0) ? cnt_q[r] - LATW'(1) : '0;
            lat_sel = '0;
            load    = 1'b0;
            for (int l = 0; l < LANES; l++) begin
                if (acc[l] && (iss_rd[l*5 +: 5] == 5'(r))) begin
                    load    = 1'b1;
                    lat_sel = iss_lat[l*LATW +: LATW];
                end
            end
            if (flush) begin
                cnt_d[r] = '0;
            end else if (load) begin
                cnt_d[r] = (dec > lat_sel) ? dec : lat_sel;
            end else begin
                cnt_d[r] = dec;
            end
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end

`ifdef FWD_STATS_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] fwd_cnt_q;
    logic [31:0] fwd_inc;
    logic [32:0] fwd_sum;

    always_comb begin : fwd_count
        fwd_inc = '0;
        if (!stall) begin
            for (int l = 0; l < LANES; l++) begin
                for (int s = 0; s < SRCS; s++) begin
                    if (iss_valid[l] && fwd_hit[l*SRCS+s]) begin
                        fwd_inc = fwd_inc + 32'd1;
                    end
                end
            end
        end
        fwd_sum = {1'b0, fwd_cnt_q} + {1'b0, fwd_inc};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            fwd_cnt_q <= fwd_sum[32] ? 32'hFFFF_FFFF : fwd_sum[31:0];
        end
    end

    assign stat_stall = stall_cnt_q;
    assign stat_fwd   = fwd_cnt_q;
`else
    logic unused_fwd_hit;
    assign unused_fwd_hit = ^fwd_hit;
    assign stat_stall     = '0;
    assign stat_fwd       = '0;
`endif

endmodule

// File: tb/tb_forward_sb.sv
// Self-checking bench for forward_sb: bypass priority, scoreboard countdown, WAW, flush, reset.
module tb_forward_sb;

    localparam int LANES  = 2;
    localparam int SRCS   = 3;
    localparam int STAGES = 2;
    localparam int LATW   = 3;
`ifdef FWD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                        clk = 1'b0;
    logic                        rstn;
    logic                        flush;
    logic [LANES-1:0]            iss_valid;
    logic [LANES-1:0]            iss_we;
    logic [LANES*5-1:0]          iss_rd;
    logic [LANES*LATW-1:0]       iss_lat;
    logic [LANES*SRCS*5-1:0]     src_reg;
    logic [LANES*SRCS*32-1:0]    src_rf;
    logic [STAGES*LANES-1:0]     byp_we;
    logic [STAGES*LANES*5-1:0]   byp_rd;
    logic [STAGES*LANES*32-1:0]  byp_data;
    logic [LANES*SRCS*32-1:0]    src_val;
    logic                        stall;
    logic [31:0]                 stat_stall;
    logic [31:0]                 stat_fwd;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    forward_sb #(.LANES(LANES), .SRCS(SRCS), .STAGES(STAGES), .LATW(LATW)) dut (
        .clk(clk), .rstn(rstn), .flush(flush),
        .iss_valid(iss_valid), .iss_we(iss_we), .iss_rd(iss_rd), .iss_lat(iss_lat),
        .src_reg(src_reg), .src_rf(src_rf),
        .byp_we(byp_we), .byp_rd(byp_rd), .byp_data(byp_data),
        .src_val(src_val), .stall(stall), .stat_stall(stat_stall), .stat_fwd(stat_fwd)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    task automatic clear_in();
        flush     = 1'b0;
        iss_valid = '0;
        iss_we    = '0;
        iss_rd    = '0;
        iss_lat   = '0;
        src_reg   = '0;
        src_rf    = '0;
        byp_we    = '0;
        byp_rd    = '0;
        byp_data  = '0;
    endtask

    task automatic set_src(input int l, input int s, input logic [4:0] r, input logic [31:0] v);
        src_reg[(l*SRCS+s)*5 +: 5]  = r;
        src_rf[(l*SRCS+s)*32 +: 32] = v;
    endtask

    task automatic set_byp(input int st, input int ln, input logic [4:0] r, input logic [31:0] d);
        byp_we[st*LANES+ln]             = 1'b1;
        byp_rd[(st*LANES+ln)*5 +: 5]    = r;
        byp_data[(st*LANES+ln)*32 +: 32] = d;
    endtask

    task automatic set_iss(input int l, input logic [4:0] r, input logic [LATW-1:0] lat);
        iss_valid[l]              = 1'b1;
        iss_we[l]                 = 1'b1;
        iss_rd[l*5 +: 5]          = r;
        iss_lat[l*LATW +: LATW]   = lat;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_in();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        clear_in();
        rstn = 1'b0;
        set_src(0, 0, 5'd2, 32'h0000_CAFE);
        step();
        step();
        exp_q.push_back(32'h0000_CAFE);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        @(negedge clk);
        exp_v = exp_q.pop_front(); checks++;
        if (src_val[31:0] !== exp_v) begin
            errors++; $display("FAIL reset_src_val: got %h want %h", src_val[31:0], exp_v);
        end
        exp_v = exp_q.pop_front(); checks++;
        if ({31'd0, stall} !== exp_v) begin
            errors++; $display("FAIL reset_stall: got %0d want %0d", stall, exp_v);
        end
        exp_v = exp_q.pop_front(); checks++;
        if (stat_stall !== exp_v) begin
            errors++; $display("FAIL reset_stat_stall: got %0d want %0d", stat_stall, exp_v);
        end
        exp_v = exp_q.pop_front(); checks++;
        if (stat_fwd !== exp_v) begin
            errors++; $display("FAIL reset_stat_fwd: got %0d want %0d", stat_fwd, exp_v);
        end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_priority();
        clear_in();
        set_src(1, 0, 5'd5, 32'h33);
        set_byp(0, 0, 5'd5, 32'h11);
        set_byp(1, 1, 5'd5, 32'h22);
        for (int i = 0; i < 3; i++) begin
            case (i)
                0: exp_q.push_back(32'h11);
                1: begin byp_we[0] = 1'b0; exp_q.push_back(32'h22); end
                default: begin byp_we[3] = 1'b0; exp_q.push_back(32'h33); end
            endcase
            @(negedge clk);
            exp_v = exp_q.pop_front(); checks++;
            if (src_val[(1*SRCS+0)*32 +: 32] !== exp_v) begin
                errors++;
                $display("FAIL priority_%0d: got %h want %h", i, src_val[(1*SRCS+0)*32 +: 32], exp_v);
            end
        end
    endtask

    task automatic test_same_stage();
        clear_in();
        set_src(1, 1, 5'd7, 32'h77);
        set_byp(0, 0, 5'd7, 32'hA);
        set_byp(0, 1, 5'd7, 32'hB);
        exp_q.push_back(32'hB);
        @(negedge clk);
        exp_v = exp_q.pop_front(); checks++;
        if (src_val[(1*SRCS+1)*32 +: 32] !== exp_v) begin
            errors++; $display("FAIL same_stage_lane: got %h want %h", src_val[(1*SRCS+1)*32 +: 32], exp_v);
        end
        clear_in();
        set_src(0, 2, 5'd0, 32'd0);
        set_byp(0, 1, 5'd0, 32'hFF);
        set_byp(1, 0, 5'd0, 32'hFF);
        exp_q.push_back(32'd0);
        @(negedge clk);
        exp_v = exp_q.pop_front(); checks++;
        if (src_val[(0*SRCS+2)*32 +: 32] !== exp_v) begin
            errors++; $display("FAIL r0_no_forward: got %h want %h", src_val[(0*SRCS+2)*32 +: 32], exp_v);
        end
    endtask

    task automatic check_stall_seq(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            exp_v = exp_q.pop_front(); checks++;
            if ({31'd0, stall} !== exp_v) begin
                errors++; $display("FAIL %s_cycle%0d: stall got %0d want %0d", tag, i, stall, exp_v);
            end
            if (i != n - 1) step();
        end
    endtask

    task automatic test_load_stall();
        do_reset();
        set_iss(0, 5'd3, 3'd2);
        step();
        clear_in();
        iss_valid[1] = 1'b1;
        set_src(1, 0, 5'd3, 32'h3);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd0);
        check_stall_seq("load_stall", 3);
        exp_q.push_back(STATS ? 32'd2 : 32'd0);
        exp_v = exp_q.pop_front(); checks++;
        if (stat_stall !== exp_v) begin
            errors++; $display("FAIL load_stat_stall: got %0d want %0d", stat_stall, exp_v);
        end
    endtask

    task automatic test_waw();
        do_reset();
        set_iss(0, 5'd4, 3'd1);
        set_iss(1, 5'd4, 3'd3);
        step();
        clear_in();
        iss_valid[1] = 1'b1;
        set_src(1, 0, 5'd4, 32'h4);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd0);
        check_stall_seq("waw_bundle", 4);

        do_reset();
        set_iss(1, 5'd4, 3'd3);
        step();
        clear_in();
        set_iss(0, 5'd4, 3'd1);
        step();
        clear_in();
        iss_valid[1] = 1'b1;
        set_src(1, 0, 5'd4, 32'h4);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd0);
        check_stall_seq("waw_max", 3);
    endtask

    task automatic test_flush();
        do_reset();
        set_iss(0, 5'd9, 3'd3);
        step();
        clear_in();
        flush = 1'b1;
        set_iss(0, 5'd10, 3'd2);
        step();
        clear_in();
        iss_valid[1] = 1'b1;
        set_src(1, 0, 5'd9, 32'h9);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        @(negedge clk);
        exp_v = exp_q.pop_front(); checks++;
        if ({31'd0, stall} !== exp_v) begin
            errors++; $display("FAIL flush_r9: stall got %0d want %0d", stall, exp_v);
        end
        set_src(1, 0, 5'd10, 32'hA);
        #2;
        exp_v = exp_q.pop_front(); checks++;
        if ({31'd0, stall} !== exp_v) begin
            errors++; $display("FAIL flush_r10: stall got %0d want %0d", stall, exp_v);
        end
    endtask

    task automatic test_fwd_stats();
        do_reset();
        iss_valid[0] = 1'b1;
        set_src(0, 0, 5'd5, 32'h1);
        set_src(0, 1, 5'd6, 32'h2);
        set_src(0, 2, 5'd8, 32'h3);
        set_byp(0, 0, 5'd5, 32'h55);
        set_byp(1, 1, 5'd6, 32'h66);
        step();
        exp_q.push_back(STATS ? 32'd2 : 32'd0);
        exp_q.push_back(32'h3);
        @(negedge clk);
        exp_v = exp_q.pop_front(); checks++;
        if (stat_fwd !== exp_v) begin
            errors++; $display("FAIL stat_fwd_count: got %0d want %0d", stat_fwd, exp_v);
        end
        exp_v = exp_q.pop_front(); checks++;
        if (src_val[2*32 +: 32] !== exp_v) begin
            errors++; $display("FAIL rf_fallback: got %h want %h", src_val[2*32 +: 32], exp_v);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_iss(0, 5'd3, 3'd3);
        step();
        clear_in();
        iss_valid[1] = 1'b1;
        set_src(1, 2, 5'd3, 32'h3);
        rstn = 1'b0;
        exp_q.push_back(32'd1);
        check_stall_seq("reset_mid_pre", 1);
        step();
        rstn = 1'b1;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd0);
        @(negedge clk);
        exp_v = exp_q.pop_front(); checks++;
        if ({31'd0, stall} !== exp_v) begin
            errors++; $display("FAIL reset_mid_stall: got %0d want %0d", stall, exp_v);
        end
        exp_v = exp_q.pop_front(); checks++;
        if (stat_stall !== exp_v) begin
            errors++; $display("FAIL reset_mid_stat_stall: got %0d want %0d", stat_stall, exp_v);
        end
        exp_v = exp_q.pop_front(); checks++;
        if (stat_fwd !== exp_v) begin
            errors++; $display("FAIL reset_mid_stat_fwd: got %0d want %0d", stat_fwd, exp_v);
        end
    endtask

    initial begin
        clear_in();
        rstn = 1'b0;
        test_reset();
        test_priority();
        test_same_stage();
        test_load_stall();
        test_waw();
        test_flush();
        test_fwd_stats();
        test_reset_mid();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
